// File: rtl/vscale_mem_arbiter_if.sv
// Bundle of the fetch port, data port and downstream memory channel seen by vscale_mem_arbiter.
// Downstream request handshake: a beat transfers on a rising edge where mem_req_valid and mem_req_ready are both high; once valid is raised it stays high with stable fields until that beat.
interface vscale_mem_arbiter_if #(
  parameter int XPR_LEN = 32
);
  logic               imem_req;
  logic [XPR_LEN-1:0] imem_addr;
  logic               imem_wait;
  logic [XPR_LEN-1:0] imem_rdata;
  logic               imem_badmem_e;

  logic               dmem_en;
  logic               dmem_wen;
  logic [2:0]         dmem_size;
  logic [XPR_LEN-1:0] dmem_addr;
  logic [XPR_LEN-1:0] dmem_wdata;
  logic               dmem_wait;
  logic [XPR_LEN-1:0] dmem_rdata;
  logic               dmem_badmem_e;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_wen;
  logic [2:0]         mem_req_size;
  logic [XPR_LEN-1:0] mem_req_addr;
  logic [XPR_LEN-1:0] mem_req_wdata;
  logic               mem_resp_valid;
  logic [XPR_LEN-1:0] mem_resp_rdata;
  logic               mem_resp_err;

  // Arbiter side.
  modport slave (
    input  imem_req, imem_addr,
    input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    output imem_wait, imem_rdata, imem_badmem_e,
    output dmem_wait, dmem_rdata, dmem_badmem_e,
    output mem_req_valid, mem_req_wen, mem_req_size, mem_req_addr, mem_req_wdata
  );

  // Environment side: the two requesters plus the memory.
  modport master (
    output imem_req, imem_addr,
    output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
    input  imem_wait, imem_rdata, imem_badmem_e,
    input  dmem_wait, dmem_rdata, dmem_badmem_e,
    input  mem_req_valid, mem_req_wen, mem_req_size, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/vscale_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory channel with a single outstanding transaction.
// Data accesses win by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module vscale_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XPR_LEN      = 32
) (
  input  logic                clk,
  input  logic                reset,
  vscale_mem_arbiter_if.slave bus,
  output logic [1:0]          state_dbg,
  output logic [3:0]          starve_cnt_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
  // Fetches are always issued as full-word reads.
  localparam logic [2:0] FETCH_SIZE  = 3'd2;
  localparam logic       OWNER_IMEM  = 1'b0;
  localparam logic       OWNER_DMEM  = 1'b1;

  state_t             state_q,      state_d;
  logic               owner_q,      owner_d;
  logic               wen_q,        wen_d;
  logic [2:0]         size_q,       size_d;
  logic [XPR_LEN-1:0] addr_q,       addr_d;
  logic [XPR_LEN-1:0] wdata_q,      wdata_d;
  logic [3:0]         starve_cnt_q, starve_cnt_d;

  logic grant_imem;
  logic complete;
  logic imem_done;
  logic dmem_done;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wen_d        = wen_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;
    complete     = 1'b0;
    grant_imem   = bus.imem_req && (!bus.dmem_en || (starve_cnt_q == STARVE_MAX));

    case (state_q)
      S_IDLE: begin
        if (bus.imem_req || bus.dmem_en) begin
          state_d = S_REQ;
          if (grant_imem) begin
            owner_d      = OWNER_IMEM;
            wen_d        = 1'b0;
            size_d       = FETCH_SIZE;
            addr_d       = bus.imem_addr;
            wdata_d      = '0;
            starve_cnt_d = '0;
          end else begin
            owner_d = OWNER_DMEM;
            wen_d   = bus.dmem_wen;
            size_d  = bus.dmem_size;
            addr_d  = bus.dmem_addr;
            wdata_d = bus.dmem_wdata;
            // Count only data grants that actually made a pending fetch wait.
            if (bus.imem_req && (starve_cnt_q < STARVE_MAX)) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.mem_resp_valid) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_IMEM;
      wen_q        <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wen_q        <= wen_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A requester that dropped its request never sees the response of its orphaned transaction.
  assign imem_done = !reset && complete && (owner_q == OWNER_IMEM) && bus.imem_req;
  assign dmem_done = !reset && complete && (owner_q == OWNER_DMEM) && bus.dmem_en;

  assign bus.imem_wait     = bus.imem_req && !imem_done;
  assign bus.imem_rdata    = imem_done ? bus.mem_resp_rdata : '0;
  assign bus.imem_badmem_e = imem_done && bus.mem_resp_err;

  assign bus.dmem_wait     = bus.dmem_en && !dmem_done;
  assign bus.dmem_rdata    = dmem_done ? bus.mem_resp_rdata : '0;
  assign bus.dmem_badmem_e = dmem_done && bus.mem_resp_err;

  assign bus.mem_req_valid = !reset && (state_q == S_REQ);
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_size  = size_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;

  assign state_dbg      = state_q;
  assign starve_cnt_dbg = starve_cnt_q;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed bench for vscale_mem_arbiter: expected downstream requests and completions are queued
// as stimulus is applied and retired by a per-cycle monitor; a simple memory responder answers each beat.
module tb_vscale_mem_arbiter;
  localparam int         XPR_LEN      = 32;
  localparam int         STARVE_LIMIT = 4;
  localparam int         REQ_W        = 1 + 3 + XPR_LEN + XPR_LEN;
  localparam logic [2:0] FETCH_SIZE   = 3'd2;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_RESP      = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  logic [3:0] starve_cnt_dbg;

  vscale_mem_arbiter_if #(.XPR_LEN(XPR_LEN)) bus ();

  vscale_mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .XPR_LEN     (XPR_LEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .state_dbg     (state_dbg),
    .starve_cnt_dbg(starve_cnt_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_cycles = 0;

  logic [REQ_W-1:0]   exp_req_q[$];
  logic [XPR_LEN:0]   exp_imem_q[$];
  logic [XPR_LEN:0]   exp_dmem_q[$];

  logic               hs_pending     = 1'b0;
  logic [XPR_LEN-1:0] hs_addr        = '0;
  logic               hold_resp      = 1'b0;
  logic               imem_auto_drop = 1'b1;
  logic               dmem_auto_drop = 1'b1;
  logic               imem_done      = 1'b0;
  logic               dmem_done      = 1'b0;

  // Memory contents and error map used by the responder and by the expectations.
  function automatic logic [XPR_LEN-1:0] mem_data(input logic [XPR_LEN-1:0] a);
    if (a == 32'h200) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic mem_err(input logic [XPR_LEN-1:0] a);
    return a == 32'h4;
  endfunction

  function automatic logic [REQ_W-1:0] pack_req(input logic wen, input logic [2:0] size,
                                                input logic [XPR_LEN-1:0] addr,
                                                input logic [XPR_LEN-1:0] wdata);
    return {wen, size, addr, wdata};
  endfunction

  task automatic chk(input string tag, input logic [REQ_W-1:0] got, input logic [REQ_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [REQ_W-1:0] got;
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      got = {bus.mem_req_wen, bus.mem_req_size, bus.mem_req_addr, bus.mem_req_wdata};
      chk("req_expected", exp_req_q.size() != 0, 1'b1);
      if (exp_req_q.size() != 0) chk("req_fields", got, exp_req_q.pop_front());
      hs_pending = 1'b1;
      hs_addr    = bus.mem_req_addr;
    end
    if (bus.imem_req && !bus.imem_wait) begin
      chk("imem_cpl_expected", exp_imem_q.size() != 0, 1'b1);
      if (exp_imem_q.size() != 0) chk("imem_cpl", {bus.imem_badmem_e, bus.imem_rdata}, exp_imem_q.pop_front());
      imem_done = 1'b1;
    end else begin
      chk("imem_passive", {bus.imem_wait, bus.imem_badmem_e, bus.imem_rdata},
          {bus.imem_req, 1'b0, {XPR_LEN{1'b0}}});
    end
    if (bus.dmem_en && !bus.dmem_wait) begin
      chk("dmem_cpl_expected", exp_dmem_q.size() != 0, 1'b1);
      if (exp_dmem_q.size() != 0) chk("dmem_cpl", {bus.dmem_badmem_e, bus.dmem_rdata}, exp_dmem_q.pop_front());
      dmem_done = 1'b1;
    end else begin
      chk("dmem_passive", {bus.dmem_wait, bus.dmem_badmem_e, bus.dmem_rdata},
          {bus.dmem_en, 1'b0, {XPR_LEN{1'b0}}});
    end
    if (bus.dmem_badmem_e) err_cycles++;
  endtask

  // Sample the current cycle at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (imem_done && imem_auto_drop) bus.imem_req = 1'b0;
    if (dmem_done && dmem_auto_drop) bus.dmem_en  = 1'b0;
    imem_done = 1'b0;
    dmem_done = 1'b0;
    if (hs_pending && !hold_resp) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = mem_data(hs_addr);
      bus.mem_resp_err   = mem_err(hs_addr);
      hs_pending         = 1'b0;
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;
      bus.mem_resp_err   = 1'b0;
    end
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_req_q.size() + exp_imem_q.size() + exp_dmem_q.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, exp_req_q.size() + exp_imem_q.size() + exp_dmem_q.size(), 0);
  endtask

  task automatic set_dmem(input logic wen, input logic [2:0] size,
                          input logic [XPR_LEN-1:0] addr, input logic [XPR_LEN-1:0] wdata);
    bus.dmem_en    = 1'b1;
    bus.dmem_wen   = wen;
    bus.dmem_size  = size;
    bus.dmem_addr  = addr;
    bus.dmem_wdata = wdata;
  endtask

  initial begin
    reset              = 1'b1;
    bus.imem_req       = 1'b1;
    bus.imem_addr      = 32'h200;
    bus.dmem_en        = 1'b1;
    bus.dmem_wen       = 1'b0;
    bus.dmem_size      = 3'd2;
    bus.dmem_addr      = 32'h1000;
    bus.dmem_wdata     = '0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    bus.mem_resp_err   = 1'b0;

    // Reset with both requesters asserting: only pass-through waits are visible.
    tick();
    tick();
    chk("rst_wait", {bus.imem_wait, bus.dmem_wait}, 2'b11);
    chk("rst_data", {bus.imem_badmem_e, bus.dmem_badmem_e, bus.imem_rdata, bus.dmem_rdata}, '0);
    chk("rst_state", {bus.mem_req_valid, state_dbg, starve_cnt_dbg}, {1'b0, ST_IDLE, 4'd0});
    reset        = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_en  = 1'b0;
    tick();
    chk("idle_after_rst", {bus.mem_req_valid, state_dbg}, {1'b0, ST_IDLE});

    // Single fetch: address on the bus in the second cycle, data in the third.
    bus.imem_req  = 1'b1;
    bus.imem_addr = 32'h200;
    exp_req_q.push_back(pack_req(1'b0, FETCH_SIZE, 32'h200, '0));
    exp_imem_q.push_back({1'b0, 32'h0000_0013});
    tick();
    chk("fetch_c2", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 32'h200});
    tick();
    chk("fetch_c3", {bus.imem_wait, bus.imem_rdata}, {1'b0, 32'h0000_0013});
    drain("fetch_drain", 20);
    tick();
    tick();
    chk("fetch_idle", state_dbg, ST_IDLE);

    // Simultaneous requests: the store goes first, then the fetch.
    bus.imem_req  = 1'b1;
    bus.imem_addr = 32'h200;
    set_dmem(1'b1, 3'd2, 32'h1000, 32'hDEAD_BEEF);
    exp_req_q.push_back(pack_req(1'b1, 3'd2, 32'h1000, 32'hDEAD_BEEF));
    exp_req_q.push_back(pack_req(1'b0, FETCH_SIZE, 32'h200, '0));
    exp_dmem_q.push_back({1'b0, mem_data(32'h1000)});
    exp_imem_q.push_back({1'b0, 32'h0000_0013});
    tick();
    chk("both_starve1", starve_cnt_dbg, 4'd1);
    drain("both_drain", 40);
    tick();
    tick();
    chk("both_starve0", {state_dbg, starve_cnt_dbg}, {ST_IDLE, 4'd0});

    // Starvation: both held high -> four data grants then one fetch, twice over.
    imem_auto_drop = 1'b0;
    dmem_auto_drop = 1'b0;
    bus.imem_req   = 1'b1;
    bus.imem_addr  = 32'h300;
    set_dmem(1'b0, 3'd1, 32'h2000, 32'h1234_5678);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < STARVE_LIMIT; i++) begin
        exp_req_q.push_back(pack_req(1'b0, 3'd1, 32'h2000, 32'h1234_5678));
        exp_dmem_q.push_back({1'b0, mem_data(32'h2000)});
      end
      exp_req_q.push_back(pack_req(1'b0, FETCH_SIZE, 32'h300, '0));
      exp_imem_q.push_back({1'b0, mem_data(32'h300)});
    end
    drain("starve_drain", 80);
    bus.imem_req   = 1'b0;
    bus.dmem_en    = 1'b0;
    imem_auto_drop = 1'b1;
    dmem_auto_drop = 1'b1;
    tick();
    tick();
    chk("starve_end", {state_dbg, starve_cnt_dbg, bus.mem_req_valid}, {ST_IDLE, 4'd0, 1'b0});

    // Error response on a load: flagged in the completing cycle only.
    err_cycles = 0;
    set_dmem(1'b0, 3'd2, 32'h4, '0);
    exp_req_q.push_back(pack_req(1'b0, 3'd2, 32'h4, '0));
    exp_dmem_q.push_back({1'b1, mem_data(32'h4)});
    drain("err_drain", 20);
    tick();
    tick();
    chk("err_cycles", err_cycles, 1);

    // Requester withdraws after the grant: the beat still goes out, the response is dropped.
    set_dmem(1'b1, 3'd0, 32'h40, 32'h55AA_55AA);
    exp_req_q.push_back(pack_req(1'b1, 3'd0, 32'h40, 32'h55AA_55AA));
    tick();
    bus.dmem_en = 1'b0;
    drain("drop_drain", 20);
    tick();
    tick();
    chk("drop_idle", {state_dbg, bus.dmem_wait}, {ST_IDLE, 1'b0});

    // Backpressure: request held stable while ready stays low.
    bus.mem_req_ready = 1'b0;
    set_dmem(1'b0, 3'd2, 32'h80, '0);
    exp_req_q.push_back(pack_req(1'b0, 3'd2, 32'h80, '0));
    exp_dmem_q.push_back({1'b0, mem_data(32'h80)});
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {bus.mem_req_valid, bus.mem_req_size, bus.mem_req_addr}, {1'b1, 3'd2, 32'h80});
      tick();
    end
    bus.mem_req_ready = 1'b1;
    drain("bp_drain", 20);
    tick();
    tick();

    // Reset while waiting for the response, then a late response arrives in IDLE.
    hold_resp = 1'b1;
    set_dmem(1'b0, 3'd2, 32'h90, '0);
    exp_req_q.push_back(pack_req(1'b0, 3'd2, 32'h90, '0));
    tick();
    tick();
    chk("rr_in_resp", {state_dbg, bus.mem_req_valid}, {ST_RESP, 1'b0});
    reset       = 1'b1;
    bus.dmem_en = 1'b0;
    tick();
    chk("rr_reset", {state_dbg, bus.mem_req_valid}, {ST_IDLE, 1'b0});
    reset     = 1'b0;
    hold_resp = 1'b0;
    tick();
    chk("rr_late_resp", {bus.mem_resp_valid, state_dbg, bus.mem_req_valid, bus.dmem_rdata},
        {1'b1, ST_IDLE, 1'b0, {XPR_LEN{1'b0}}});
    tick();
    chk("rr_stay_idle", {state_dbg, starve_cnt_dbg}, {ST_IDLE, 4'd0});
    drain("final_drain", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
